// File: rtl/uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_ctrl
// Purpose  : Bus-facing UART controller. Queues CPU-written bytes in a TX FIFO
//            and launches them one frame at a time into the byte transmitter;
//            drains the receiver's sticky data-ready flag into an RX FIFO.
//            Exposes a data register (addr 0) and a status register (addr 1).
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_valid/we/addr/wdata - one-cycle bus request
//            resp_valid/rdata    - registered response, one cycle later
//            tx_start/tx_data    - launch pulse and byte to transmitter
//            tx_busy             - transmitter busy (rises after tx_start)
//            rx_ready/rx_data    - receiver sticky byte-available + byte
//            rx_clear            - one-cycle clear of rx_ready
// Status   : bit0 TX not full, bit1 RX not empty, bit2 TX idle,
//            bit3 RX overflow (sticky, cleared by status read)
// Revision : 1.0 - initial release
// ============================================================================
module uart_ctrl #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic        req_addr,
  input  logic [7:0]  req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        rx_clear
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  localparam logic [1:0] TX_IDLE   = 2'd0;
  localparam logic [1:0] TX_LAUNCH = 2'd1;
  localparam logic [1:0] TX_GUARD  = 2'd2;
  localparam logic [1:0] TX_WAIT   = 2'd3;

  localparam logic RX_IDLE  = 1'b0;
  localparam logic RX_CLEAR = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [TX_AW-1:0] tx_wptr_q, tx_rptr_q;
  logic [TX_AW:0]   tx_cnt_q;
  logic [7:0]       tx_data_q;
  logic [1:0]       tx_state_q, tx_state_d;

  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [RX_AW-1:0] rx_wptr_q, rx_rptr_q;
  logic [RX_AW:0]   rx_cnt_q;
  logic             rx_state_q, rx_state_d;
  logic             ovf_q, ovf_d;

  logic             resp_valid_q;
  logic [31:0]      resp_rdata_q, resp_rdata_d;

  // --------------------------------------------------------------------------
  // Decode and FIFO handshakes
  // --------------------------------------------------------------------------
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop, ovf_set, stat_rd;
  logic tx_idle;
  logic [31:0] status;

  assign tx_full  = (tx_cnt_q == (TX_AW+1)'(TX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == (RX_AW+1)'(RX_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  // The transmitter is only fed from TX_IDLE, and only once it has dropped busy
  // (also covers a frame still running after a controller reset).
  assign tx_pop  = (tx_state_q == TX_IDLE) && !tx_empty && !tx_busy;
  // A same-cycle pop frees a slot, so a write into a full FIFO still lands.
  assign tx_push = req_valid && req_we && !req_addr && (!tx_full || tx_pop);

  assign rx_pop  = req_valid && !req_we && !req_addr && !rx_empty;
  assign rx_push = (rx_state_q == RX_IDLE) && rx_ready && (!rx_full || rx_pop);
  assign ovf_set = (rx_state_q == RX_IDLE) && rx_ready && rx_full && !rx_pop;
  assign stat_rd = req_valid && !req_we && req_addr;

  assign tx_idle = tx_empty && (tx_state_q == TX_IDLE) && !tx_busy;
  assign status  = {28'd0, ovf_q, tx_idle, !rx_empty, !tx_full};

  // Set beats a concurrent status-read clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (stat_rd) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    resp_rdata_d = 32'd0;
    if (req_valid && !req_we) begin
      if (req_addr) begin
        resp_rdata_d = status;
      end else if (!rx_empty) begin
        resp_rdata_d = {24'd0, rx_mem_q[rx_rptr_q]};
      end
    end
  end

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem_q[tx_wptr_q] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      tx_data_q <= 8'd0;
    end else begin
      if (tx_push) begin
        tx_wptr_q <= tx_wptr_q + TX_AW'(1);
      end
      if (tx_pop) begin
        tx_rptr_q <= tx_rptr_q + TX_AW'(1);
        tx_data_q <= tx_mem_q[tx_rptr_q];
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + (TX_AW+1)'(1);
        2'b01:   tx_cnt_q <= tx_cnt_q - (TX_AW+1)'(1);
        default: tx_cnt_q <= tx_cnt_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // RX FIFO, overflow flag and bus response
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem_q[rx_wptr_q] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      rx_cnt_q     <= '0;
      ovf_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      if (rx_push) begin
        rx_wptr_q <= rx_wptr_q + RX_AW'(1);
      end
      if (rx_pop) begin
        rx_rptr_q <= rx_rptr_q + RX_AW'(1);
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + (RX_AW+1)'(1);
        2'b01:   rx_cnt_q <= rx_cnt_q - (RX_AW+1)'(1);
        default: rx_cnt_q <= rx_cnt_q;
      endcase
      ovf_q        <= ovf_d;
      resp_valid_q <= req_valid;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // TX FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
    end else begin
      tx_state_q <= tx_state_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:   if (tx_pop) tx_state_d = TX_LAUNCH;
      TX_LAUNCH: tx_state_d = TX_GUARD;
      // tx_busy only rises the cycle after tx_start; skip that cycle.
      TX_GUARD:  tx_state_d = TX_WAIT;
      TX_WAIT:   if (!tx_busy) tx_state_d = TX_IDLE;
      default:   tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_start = (tx_state_q == TX_LAUNCH);
  end

  // --------------------------------------------------------------------------
  // RX FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
    end else begin
      rx_state_q <= rx_state_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (rx_ready) rx_state_d = RX_CLEAR;
      RX_CLEAR: rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_clear = (rx_state_q == RX_CLEAR);
  end

  assign tx_data    = tx_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_ctrl
// Purpose  : Directed self-checking bench for uart_ctrl with a simple
//            transmitter model (busy for 10 cycles after each tx_start) and
//            a sticky-flag receiver driven from the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rx_clear;

  always #5 clk = ~clk;

  uart_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_clear   (rx_clear)
  );

  // Transmitter model: every launched byte is logged; busy for 10 cycles.
  logic [7:0] sent [$];
  int         busy_cnt = 0;
  int         start_while_busy = 0;
  int         clr_cnt = 0;
  logic       busy_force;

  assign tx_busy = busy_force | (busy_cnt != 0);

  always @(posedge clk) begin
    if (tx_start) begin
      sent.push_back(tx_data);
      busy_cnt <= 10;
      if (tx_busy) start_while_busy <= start_while_busy + 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (rx_clear) clr_cnt <= clr_cnt + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic we, input logic addr, input logic [7:0] wd,
                     output logic [31:0] rd);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 1'b0; req_wdata = 8'd0;
    check("resp_valid", {31'd0, resp_valid}, 32'd1);
    rd = resp_rdata;
  endtask

  task automatic wr(input logic [7:0] d);
    logic [31:0] rd;
    bus(1'b1, 1'b0, d, rd);
    check("wr_rdata_zero", rd, 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic addr, input logic [31:0] exp);
    logic [31:0] rd;
    bus(1'b0, addr, 8'd0, rd);
    check(tag, rd, exp);
  endtask

  task automatic rx_deliver(input logic [7:0] b);
    bit seen = 1'b0;
    rx_data = b; rx_ready = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      if (rx_clear) seen = 1'b1;
    end
    if (!seen) check("rx_clear_seen", 32'd0, 32'd1);
    // Receiver drops its flag at the edge that samples rx_clear.
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_start"},   {31'd0, tx_start},   32'd0);
    check({tag, "_tx_data"},    {24'd0, tx_data},    32'd0);
    check({tag, "_rx_clear"},   {31'd0, rx_clear},   32'd0);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata,          32'd0);
  endtask

  initial begin
    int base;
    int c0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 1'b0; req_wdata = 8'd0;
    rx_ready = 1'b0; rx_data = 8'd0; busy_force = 1'b0;
    cycles(3);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Idle status: TX not full + TX idle.
    rd_chk("status_after_reset", 1'b1, 32'h5);

    // Two back-to-back writes, launched in order, second only after busy falls.
    base = sent.size();
    wr(8'h41);
    wr(8'h42);
    cycles(40);
    check("tx_two_count", sent.size() - base, 2);
    check("tx_first_byte",  {24'd0, sent[base]},   32'h41);
    check("tx_second_byte", {24'd0, sent[base+1]}, 32'h42);
    check("start_while_busy", start_while_busy, 0);
    rd_chk("status_tx_done", 1'b1, 32'h5);

    // One byte in flight plus 8 queued; the 10th write is dropped.
    base = sent.size();
    wr(8'h10);
    cycles(4);
    busy_force = 1'b1;
    for (int i = 0; i < 9; i++) wr(8'h11 + 8'(i));
    rd_chk("status_tx_full", 1'b1, 32'h0);
    busy_force = 1'b0;
    cycles(200);
    check("tx_full_count", sent.size() - base, 9);
    for (int i = 0; i < 9; i++)
      check("tx_full_order", {24'd0, sent[base+i]}, 32'h10 + i);
    check("start_while_busy_2", start_while_busy, 0);

    // Single received byte.
    c0 = clr_cnt;
    rx_deliver(8'h5A);
    cycles(2);
    check("rx_clear_pulses", clr_cnt - c0, 1);
    rd_chk("status_rx_avail", 1'b1, 32'h7);
    rd_chk("rx_read_5a", 1'b0, 32'h5A);
    rd_chk("rx_read_empty", 1'b0, 32'h0);

    // Nine bytes into an 8-deep RX FIFO: overflow; TX held busy so bit2 = 0.
    busy_force = 1'b1;
    for (int i = 0; i < 9; i++) rx_deliver(8'h60 + 8'(i));
    rd_chk("status_overflow", 1'b1, 32'hB);
    rd_chk("status_ovf_cleared", 1'b1, 32'h3);
    for (int i = 0; i < 8; i++) rd_chk("rx_order", 1'b0, 32'h60 + i);
    rd_chk("rx_read_empty_2", 1'b0, 32'h0);
    busy_force = 1'b0;
    cycles(15);

    // Reset while waiting on the transmitter with 3 bytes queued.
    base = sent.size();
    wr(8'h21);
    cycles(4);
    busy_force = 1'b1;
    wr(8'h22); wr(8'h23); wr(8'h24);
    rst = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("midframe_rst");
    rst = 1'b0;
    cycles(20);
    check("rst_no_relaunch", sent.size() - base, 1);
    rd_chk("status_rst_busy", 1'b1, 32'h1);
    busy_force = 1'b0;
    cycles(30);
    check("rst_fifo_empty", sent.size() - base, 1);
    rd_chk("status_rst_idle", 1'b1, 32'h5);
    wr(8'h77);
    cycles(20);
    check("post_rst_count", sent.size() - base, 2);
    check("post_rst_byte", {24'd0, sent[base+1]}, 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
